// File: rtl/gmii_tx_sched_pkg.sv
// Shared definitions for the GMII transmit scheduler and its CRC helper.
// Contents: Ethernet framing constants, CRC-32 constants, TX FSM state type,
// and the bit offset of each FCS byte in transmit order.
package gmii_tx_sched_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          PREAMBLE_LEN    = 7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_e;

    // FCS goes out least-significant byte first; entry k is the LSB of byte k.
    localparam logic [3:0][4:0] FCS_BYTE_LSB = {5'd24, 5'd16, 5'd8, 5'd0};

endpackage

// File: rtl/gmii_tx_sched_if.sv
// Source-side byte streams of the GMII transmit scheduler.
// Two independent valid/ready byte channels (s0 = CPU path, s1 = forwarding).
//   master : the packet sources (drive valid/data/last, observe ready)
//   slave  : the scheduler (observes valid/data/last, drives ready)
interface gmii_tx_sched_if;

    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;

    modport master (
        output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
        input  s0_ready, s1_ready
    );

    modport slave (
        input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
        output s0_ready, s1_ready
    );

endinterface

// File: rtl/gmii_tx_sched_crc32_d8.sv
// Combinational CRC-32 update for one byte, reflected (LSB-first) form.
// Shared between TX FCS generation and a future RX FCS checker.
//   crc_i  : running CRC before this byte
//   data_i : byte to fold in
//   crc_o  : running CRC after this byte (not inverted)
module crc32_d8
    import gmii_tx_sched_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_tx_sched.sv
// Two-source frame scheduler driving one GMII TX port.
// Arbitrates whole frames round-robin, prepends preamble/SFD, pads short
// frames, appends the CRC-32 FCS and holds the inter-frame gap.
//   clk, rst_n    : GMII TX clock, async active-low reset
//   src_if        : slave side of the two source byte channels
//   gmii_en_o     : TX_EN
//   gmii_er_o     : TX_ER (only on an underrun cycle)
//   gmii_data_o   : TXD, zero whenever TX_EN is low
//   grant_o       : one-hot frame owner, 00 when none
//   busy_o        : FSM is not idle
//
// The state names the byte being loaded into the output register this cycle,
// so everything on the wire lags the state by one cycle: a byte accepted in
// cycle n is on TXD in cycle n+1, and TX_EN first rises the cycle after
// grant_o does.
module gmii_tx_sched
    import gmii_tx_sched_pkg::*;
#(
    parameter int unsigned MIN_LEN    = 60,
    parameter int unsigned IFG_CYCLES = 12,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    gmii_tx_sched_if.slave   src_if,
    output logic             gmii_en_o,
    output logic             gmii_er_o,
    output logic [7:0]       gmii_data_o,
    output logic [1:0]       grant_o,
    output logic             busy_o
);

    tx_state_e   state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        rr_q, rr_d;        // source preferred on a tie
    logic [15:0] cnt_q, cnt_d;      // frame bytes sent so far (saturating)
    logic [15:0] tmr_q, tmr_d;      // phase counter for PRE / FCS / IFG
    logic [31:0] crc_q, crc_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic [7:0]  data_q, data_d;

    logic        g_valid, g_last, acc_win, sel;
    logic [7:0]  g_data, crc_byte;
    logic [31:0] crc_nxt, fcs;
    logic [15:0] cnt_inc;

    assign g_valid = grant_q[1] ? src_if.s1_valid : src_if.s0_valid;
    assign g_data  = grant_q[1] ? src_if.s1_data  : src_if.s0_data;
    assign g_last  = grant_q[1] ? src_if.s1_last  : src_if.s0_last;

    // Ready is offered in DATA (transmit) and DRAIN (discard) only.
    assign acc_win         = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign src_if.s0_ready = acc_win & grant_q[0];
    assign src_if.s1_ready = acc_win & grant_q[1];

    assign crc_byte = (state_q == ST_PAD) ? PAD_BYTE : g_data;
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign fcs      = ~crc_q;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_nxt)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        crc_d   = crc_q;
        en_d    = 1'b0;
        er_d    = 1'b0;
        data_d  = 8'h00;
        sel     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (src_if.s0_valid || src_if.s1_valid) begin
                    sel     = (src_if.s0_valid && src_if.s1_valid) ? rr_q : src_if.s1_valid;
                    grant_d = sel ? 2'b10 : 2'b01;
                    rr_d    = ~sel;
                    tmr_d   = '0;
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                en_d   = 1'b1;
                data_d = PREAMBLE_BYTE;
                tmr_d  = tmr_q + 16'd1;
                if (tmr_q == 16'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                en_d    = 1'b1;
                data_d  = SFD_BYTE;
                cnt_d   = '0;
                crc_d   = CRC32_INIT;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                en_d = 1'b1;
                if (g_valid) begin
                    data_d = g_data;
                    crc_d  = crc_nxt;
                    cnt_d  = cnt_inc;
                    if (g_last) begin
                        tmr_d   = '0;
                        state_d = ((32'(cnt_q) + 32'd1) < MIN_LEN) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Underrun: flag the frame as errored on the wire, then discard.
                    er_d    = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_PAD: begin
                en_d   = 1'b1;
                data_d = PAD_BYTE;
                crc_d  = crc_nxt;
                cnt_d  = cnt_inc;
                if ((32'(cnt_q) + 32'd1) >= MIN_LEN) begin
                    tmr_d   = '0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                en_d   = 1'b1;
                data_d = fcs[FCS_BYTE_LSB[tmr_q[1:0]] +: 8];
                tmr_d  = tmr_q + 16'd1;
                if (tmr_q[1:0] == 2'd3) begin
                    tmr_d   = '0;
                    grant_d = '0;
                    state_d = ST_IFG;
                end
            end
            ST_DRAIN: begin
                if (g_valid && g_last) begin
                    tmr_d   = '0;
                    grant_d = '0;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                tmr_d = tmr_q + 16'd1;
                if (tmr_q == 16'(IFG_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            crc_q   <= CRC32_INIT;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            crc_q   <= crc_d;
            en_q    <= en_d;
            er_q    <= er_d;
            data_q  <= data_d;
        end
    end

    assign gmii_en_o   = en_q;
    assign gmii_er_o   = er_q;
    assign gmii_data_o = data_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched. Two instances: dut_a with MIN_LEN=0 and
// dut_b with default parameters; dsel picks which one gets stimulus and is
// observed. A negedge monitor records wire bytes, gaps, grants and latencies.
`timescale 1ns/1ps
module tb_gmii_tx_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dsel = 1'b0;

    logic       s0v = 1'b0, s0l = 1'b0, s1v = 1'b0, s1l = 1'b0;
    logic [7:0] s0d = 8'h00, s1d = 8'h00;

    gmii_tx_sched_if ifa ();
    gmii_tx_sched_if ifb ();

    logic       en_a, er_a, busy_a, en_b, er_b, busy_b;
    logic [7:0] d_a, d_b;
    logic [1:0] g_a, g_b;

    always #4 clk = ~clk;

    assign ifa.s0_valid = s0v & ~dsel;
    assign ifa.s1_valid = s1v & ~dsel;
    assign ifb.s0_valid = s0v & dsel;
    assign ifb.s1_valid = s1v & dsel;
    assign ifa.s0_data  = s0d;
    assign ifa.s1_data  = s1d;
    assign ifb.s0_data  = s0d;
    assign ifb.s1_data  = s1d;
    assign ifa.s0_last  = s0l;
    assign ifa.s1_last  = s1l;
    assign ifb.s0_last  = s0l;
    assign ifb.s1_last  = s1l;

    gmii_tx_sched #(.MIN_LEN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .src_if(ifa.slave),
        .gmii_en_o(en_a), .gmii_er_o(er_a), .gmii_data_o(d_a),
        .grant_o(g_a), .busy_o(busy_a)
    );

    gmii_tx_sched dut_b (
        .clk(clk), .rst_n(rst_n), .src_if(ifb.slave),
        .gmii_en_o(en_b), .gmii_er_o(er_b), .gmii_data_o(d_b),
        .grant_o(g_b), .busy_o(busy_b)
    );

    logic       m_en, m_er, m_busy, rdy0, rdy1;
    logic [7:0] m_data;
    logic [1:0] m_grant;
    assign m_en    = dsel ? en_b   : en_a;
    assign m_er    = dsel ? er_b   : er_a;
    assign m_busy  = dsel ? busy_b : busy_a;
    assign m_data  = dsel ? d_b    : d_a;
    assign m_grant = dsel ? g_b    : g_a;
    assign rdy0    = dsel ? ifb.s0_ready : ifa.s0_ready;
    assign rdy1    = dsel ? ifb.s1_ready : ifa.s1_ready;

    // ---------------- monitor ----------------
    logic [7:0] cap_d[$];
    logic       cap_e[$];
    int         gaps[$];
    logic [1:0] grants[$];
    int         lats[$];
    int er_cnt = 0, bad_idle = 0, rdy_hi = 0, low_run = 0, lat_cnt = 0;
    logic en_prev = 1'b0, seen_frame = 1'b0, lat_arm = 1'b0;
    logic [1:0] grant_prev = 2'b00;

    always @(negedge clk) begin
        if (m_en) begin
            cap_d.push_back(m_data);
            cap_e.push_back(m_er);
            if (!en_prev && seen_frame) gaps.push_back(low_run);
            low_run    <= 0;
            seen_frame <= 1'b1;
        end else begin
            low_run <= low_run + 1;
        end
        if (m_er) er_cnt <= er_cnt + 1;
        if (!m_en && (m_er || m_data != 8'h00)) bad_idle <= bad_idle + 1;
        if (rdy0 || rdy1) rdy_hi <= rdy_hi + 1;
        en_prev <= m_en;
        if (m_grant != 2'b00 && grant_prev == 2'b00) begin
            grants.push_back(m_grant);
            lat_cnt <= 0;
            lat_arm <= 1'b1;
        end else if (lat_arm) begin
            if (m_en) begin
                lats.push_back(lat_cnt + 1);
                lat_arm <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
        grant_prev <= m_grant;
    end

    // ---------------- helpers ----------------
    int n_chk = 0, n_fail = 0;
    int acc0 = 0, acc1 = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int s, input int fid, input int i);
        if (fid == 1) return 8'(32'h31 + i);
        if (fid == 2) return 8'hAB;
        return 8'((s * 64) + (fid * 7) + (i * 3) + 1);
    endfunction

    task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
        if (s == 0) begin s0v = v; s0d = d; s0l = l; end
        else        begin s1v = v; s1d = d; s1l = l; end
    endtask

    task automatic do_reset(input logic sel);
        set_src(0, 1'b0, 8'h00, 1'b0);
        set_src(1, 1'b0, 8'h00, 1'b0);
        dsel  = sel;
        rst_n = 1'b0;
        acc0  = 0;
        acc1  = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents one frame; gap_at >= 0 drops valid for one cycle before that byte.
    task automatic drive(input int s, input int len, input int gap_at, input int fid);
        int i = 0, cyc = 0;
        bit gapped = 0, aborted = 0;
        logic v, r;
        while (i < len && cyc < 4000) begin
            v = !(i == gap_at && !gapped);
            if (i == gap_at) gapped = 1;
            set_src(s, v, pat(s, fid, i), i == len - 1);
            @(negedge clk);
            r = (s == 0) ? rdy0 : rdy1;
            @(posedge clk); #1;
            if (!rst_n) begin aborted = 1; break; end
            if (v && r) begin
                i++;
                if (s == 0) acc0++; else acc1++;
            end
            cyc++;
        end
        set_src(s, 1'b0, 8'h00, 1'b0);
        chk($sformatf("drv%0d_done", s), (i == len) || aborted, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (m_busy && n < 3000) begin @(negedge clk); n++; end
        chk(tag, n < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic build_exp(input int s, input int fid, input int len, input int minlen);
        logic [31:0] c;
        logic [7:0] b;
        int tot;
        exp_q.delete();
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        tot = (len < minlen) ? minlen : len;
        for (int i = 0; i < tot; i++) begin
            b = (i < len) ? pat(s, fid, i) : 8'h00;
            exp_q.push_back(b);
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic verify(input string tag, input int base);
        int n;
        n = cap_d.size() - base;
        chk($sformatf("%s_len", tag), n, exp_q.size());
        for (int k = 0; k < exp_q.size() && k < n; k++)
            chk($sformatf("%s_b%0d", tag, k), cap_d[base + k], exp_q[k]);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {m_en, m_er, m_data, m_grant, m_busy, rdy0, rdy1}, 0);
    endtask

    // ---------------- tests ----------------
    initial begin
        int base, erb, rb, gb, gpb, n;

        // Reset state of both instances
        rst_n = 1'b0;
        #3;
        dsel = 1'b0; #1 chk_zero("rst_a");
        dsel = 1'b1; #1 chk_zero("rst_b");

        // 1: "123456789", no padding
        do_reset(1'b0);
        base = cap_d.size(); erb = er_cnt;
        drive(0, 9, -1, 1);
        wait_idle("t1_idle");
        build_exp(0, 1, 9, 0);
        verify("t1", base);
        chk("t1_fcs0", cap_d[base + 17], 8'h26);
        chk("t1_fcs1", cap_d[base + 18], 8'h39);
        chk("t1_fcs2", cap_d[base + 19], 8'hF4);
        chk("t1_fcs3", cap_d[base + 20], 8'hCB);
        chk("t1_er", er_cnt - erb, 0);
        chk("t1_lat", lats[lats.size() - 1], 1);
        chk("t1_ifg", low_run >= 12, 1);

        // 2: 10-byte frame on s1 padded to 60
        do_reset(1'b1);
        base = cap_d.size(); gb = grants.size();
        drive(1, 10, -1, 3);
        wait_idle("t2_idle");
        build_exp(1, 3, 10, 60);
        verify("t2", base);
        chk("t2_len72", cap_d.size() - base, 72);
        chk("t2_grant", grants[gb], 2'b10);
        chk("t2_lat", lats[lats.size() - 1], 1);

        // 3: both sources, three 64-byte frames each
        do_reset(1'b1);
        base = cap_d.size(); gb = grants.size(); gpb = gaps.size();
        fork
            begin for (int f = 0; f < 3; f++) drive(0, 64, -1, 4 + f); end
            begin for (int f = 0; f < 3; f++) drive(1, 64, -1, 4 + f); end
        join
        wait_idle("t3_idle");
        chk("t3_ngrant", grants.size() - gb, 6);
        for (int k = 0; k < 6 && gb + k < grants.size(); k++)
            chk($sformatf("t3_grant%0d", k), grants[gb + k], (k % 2 == 0) ? 2'b01 : 2'b10);
        n = gaps.size();
        chk("t3_ngap", n - gpb >= 5, 1);
        for (int k = 0; k < 5 && n - 1 - k >= 0; k++)
            chk($sformatf("t3_gap%0d", k), gaps[n - 1 - k] >= 13, 1);
        chk("t3_bytes", cap_d.size() - base, 6 * 76);

        // 4: underrun at byte 20
        do_reset(1'b1);
        base = cap_d.size(); erb = er_cnt;
        drive(0, 64, 20, 6);
        wait_idle("t4_idle");
        chk("t4_len", cap_d.size() - base, 29);
        chk("t4_sfd", cap_d[base + 7], 8'hD5);
        chk("t4_b19", cap_d[base + 27], pat(0, 6, 19));
        chk("t4_b19_er", cap_e[base + 27], 0);
        chk("t4_err_d", cap_d[base + 28], 8'h00);
        chk("t4_err_e", cap_e[base + 28], 1);
        chk("t4_er_cnt", er_cnt - erb, 1);
        chk("t4_ifg", low_run >= 12, 1);

        // 5: reset during DATA byte 30, then a clean s1 frame
        do_reset(1'b1);
        fork
            drive(1, 64, -1, 7);
            begin
                n = 0;
                while (acc1 < 30 && n < 2000) begin @(posedge clk); #2; n++; end
                chk("t5_reach30", acc1, 30);
                rst_n = 1'b0;
                #1;
                chk_zero("t5_async");
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        join
        @(posedge clk); #1;
        base = cap_d.size(); gb = grants.size();
        drive(1, 64, -1, 8);
        wait_idle("t5_idle");
        build_exp(1, 8, 64, 60);
        verify("t5", base);
        chk("t5_grant", grants[gb], 2'b10);

        // 6: single-byte frame, no padding
        do_reset(1'b0);
        base = cap_d.size(); rb = rdy_hi;
        drive(0, 1, -1, 2);
        wait_idle("t6_idle");
        build_exp(0, 2, 1, 0);
        verify("t6", base);
        chk("t6_ready", rdy_hi - rb, 1);

        chk("idle_clean", bad_idle, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_tx_sched.md
Name: gmii_tx_sched

Overview:
- Two-requester transmit scheduler for a single GMII TX port.
- Arbitrates whole frames between source 0 (CPU/runtime packet output) and source 1 (forwarding path).
- Adds the 7-byte preamble and the SFD, pads to minimum length, appends the CRC-32 FCS and enforces the inter-frame gap.
- It is the TX-side counterpart of the RX FCS-stripping pipeline and drives the PHY's GMII TX pins directly.

Parameters:
- MIN_LEN, 60, minimum payload bytes before FCS (0 disables padding).
- IFG_CYCLES, 12, idle cycles forced after each frame (must be >=1).
- PAD_BYTE, 8'h00, fill byte used for padding.

Ports:
- clk  input  1  GMII TX clock (125 MHz).
- rst_n  input  1  reset; asynchronous, active-low.
- s0_valid  input  1  source 0 byte valid.
- s0_data  input  8  source 0 byte.
- s0_last  input  1  source 0 last byte of frame.
- s0_ready  output  1  source 0 byte accepted when valid&ready.
- s1_valid / s1_data / s1_last / s1_ready: same as source 0, for source 1.
- gmii_en_o  output  1  GMII TX_EN.
- gmii_er_o  output  1  GMII TX_ER.
- gmii_data_o  output  8  GMII TXD.
- grant_o  output  2  one-hot current owner; 00 when idle.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async) forces:
  - gmii_en_o=0, gmii_er_o=0, gmii_data_o=0, s*_ready=0, grant_o=0, busy_o=0.
  - state=IDLE, rr pointer=source 0 preferred.
- A reset asserted mid-frame drops TX_EN immediately; no FCS is emitted.
- All GMII outputs are registered. A byte accepted in cycle n appears on gmii_data_o in cycle n+1.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE:
  - If exactly one s*_valid is high, grant that source.
  - If both are high, grant the source not granted last (round-robin); the rr pointer updates on each grant.
  - Go to PRE. The grant holds until the frame leaves FCS or DRAIN.
- PRE: 7 cycles, en=1, data=8'h55. First en cycle is the cycle after the grant.
- SFD: 1 cycle, en=1, data=8'hD5. Clear the 16-bit saturating byte counter; CRC=32'hFFFFFFFF.
- DATA:
  - Ready is high only for the granted source.
  - Each accepted byte is driven with en=1, folded into the CRC, and increments the counter.
  - On an accepted last: if count+1 < MIN_LEN go to PAD, else go to FCS.
- Underrun (granted valid low while in DATA): drive one cycle en=1, er=1, data=0, then go to DRAIN.
- DRAIN:
  - en=0; granted ready=1; discard bytes until last is accepted, then go to IFG.
  - No FCS is sent for an aborted frame.
- PAD: emit PAD_BYTE, folded into the CRC, until count==MIN_LEN, then go to FCS.
- CRC:
  - Reflected CRC-32, poly 0xEDB88320, init all-ones.
  - FCS = ~crc, sent as bytes [7:0], [15:8], [23:16], [31:24] over 4 cycles, en=1.
- IFG: en=0 for exactly IFG_CYCLES, then go to IDLE. Requests pending during IFG wait.
- The non-granted source's ready is always 0.
- A 1-byte frame (valid&last on the first DATA cycle) is legal.
- gmii_er_o is 0 in every case except the underrun cycle.
- gmii_data_o is 0 whenever en=0.
- Minimum spacing between frames is therefore IFG_CYCLES plus 1 IDLE cycle.

Decomposition:
- Shared package holds:
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7, CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF;
  - the state enum typedef;
  - a 4-entry FCS byte-index constant.
- Sub-module crc32_d8: combinational next-CRC for an 8-bit input (reflected). It is reusable by a future RX FCS checker.
- The arbiter, FSM and counters stay in gmii_tx_sched.

Test Plan:
- MIN_LEN=0, s0 sends ASCII "123456789" -> TXD shows 55 x7, D5, 31..39, then 26 39 F4 CB; en high for 21 cycles; er never high; then en low for 12 cycles.
- Default params, s1 sends a 10-byte frame -> 10 data bytes then 50 bytes 00, then the FCS of the 60-byte buffer matching the bench model; en high for 72 cycles.
- s0 and s1 both valid in the same cycle, each holding 3 back-to-back 64-byte frames -> grants alternate s0, s1, s0, s1...; each IDLE-to-PRE gap is >= 13 cycles.
- s0 valid dropped at byte 20 -> one cycle en=1, er=1, data=00; then en=0; remaining bytes accepted with ready=1 until last; no FCS; IFG follows.
- rst_n pulsed low during DATA byte 30 -> en, er, data and ready go 0 asynchronously; after release, a new s1 frame transmits a correct preamble and FCS.
- Single-byte frame AB with MIN_LEN=0 -> 55 x7, D5, AB, then the 4 FCS bytes of the 1-byte CRC; ready high for exactly 1 cycle.
